mem_resp_bram: RTL and testbench



---
 rtl/mem_resp_if.sv | 21 ++
 rtl/mem_resp_bram.sv | 166 ++++++++++++++++
 tb/tb_mem_resp_bram.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_resp_if.sv
// Single-word memory request/response bundle between a cache DRAM-side port and its responder.
interface mem_resp_if;
    logic        i_rd_en;
    logic        i_wr_en;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic [3:0]  i_ctrl;
    logic [31:0] o_data;
    logic        o_busy;
    logic        o_init_done;

    modport master (
        output i_rd_en, i_wr_en, i_addr, i_data, i_ctrl,
        input  o_data, o_busy, o_init_done
    );

    modport slave (
        input  i_rd_en, i_wr_en, i_addr, i_data, i_ctrl,
        output o_data, o_busy, o_init_done
    );
endinterface

// File: rtl/mem_resp_bram.sv
// Block-RAM responder emulating an SDRAM controller's init phase, fixed latency and byte-masked writes.
// Define MEM_RESP_REFRESH_EN to add periodic refresh stalls with request latching.
module mem_resp_bram #(
    parameter int ADDR_WIDTH     = 16,
    parameter int LATENCY        = 4,
    parameter int INIT_CYCLES    = 16,
    parameter     PRELOAD_FILE   = "",
    parameter int REFRESH_PERIOD = 512,
    parameter int REFRESH_CYCLES = 8
) (
    input logic        clk,
    input logic        rst,
    mem_resp_if.slave  bus
);
    localparam int WA    = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << WA;

    localparam logic [1:0] S_INIT   = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    localparam logic [31:0] LAT_LAST  = 32'(LATENCY - 1);
    localparam logic [31:0] INIT_LAST = (INIT_CYCLES > 0) ? 32'(INIT_CYCLES - 1) : 32'd0;

    logic [1:0]    state;
    logic [31:0]   cnt;
    logic          busy;
    logic          init_done;
    logic [31:0]   rdata;
    logic          acc_wr;
    logic [WA-1:0] acc_addr;
    logic [31:0]   acc_data;
    logic [3:0]    acc_strb;
    logic          req;
    logic          commit_wr;
    logic [31:0]   unused_addr;

    logic [31:0] mem [DEPTH];

    // Array image is a power-up property of the RAM, so it survives reset.
    initial for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;

    assign req         = bus.i_rd_en | bus.i_wr_en;
    assign unused_addr = bus.i_addr;
    assign commit_wr   = (state == S_ACCESS) && (cnt == LAT_LAST) && acc_wr;

    always_ff @(posedge clk) begin
        if (commit_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_strb[b]) mem[acc_addr][8*b +: 8] <= acc_data[8*b +: 8];
            end
        end
    end

`ifdef MEM_RESP_REFRESH_EN
    localparam logic [1:0]  S_REFRESH = 2'd3;
    localparam logic [31:0] RF_LAST   = (REFRESH_CYCLES > 0) ? 32'(REFRESH_CYCLES - 1) : 32'd0;

    logic [31:0] ref_cnt;
    logic        ref_due;
    logic        pend_vld;

    assign ref_due = (ref_cnt >= 32'(REFRESH_PERIOD));

    // Counter saturates when due, so an expiry during ACCESS waits for the next IDLE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   ref_cnt <= 32'd0;
        else if (state == S_REFRESH)               ref_cnt <= 32'd0;
        else if (state != S_INIT && !ref_due)      ref_cnt <= ref_cnt + 32'd1;
    end
`else
    logic [63:0] unused_refresh_cfg;
    assign unused_refresh_cfg = {32'(REFRESH_PERIOD), 32'(REFRESH_CYCLES)};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_INIT;
            cnt       <= 32'd0;
            busy      <= 1'b1;
            init_done <= 1'b0;
            rdata     <= 32'd0;
            acc_wr    <= 1'b0;
            acc_addr  <= '0;
            acc_data  <= 32'd0;
            acc_strb  <= 4'd0;
`ifdef MEM_RESP_REFRESH_EN
            pend_vld  <= 1'b0;
`endif
        end else begin
            case (state)
                S_INIT: begin
                    if (cnt >= INIT_LAST) begin
                        state     <= S_IDLE;
                        cnt       <= 32'd0;
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_IDLE: begin
                    if (req) begin
                        acc_wr   <= bus.i_wr_en;
                        acc_addr <= bus.i_addr[ADDR_WIDTH-1:2];
                        acc_data <= bus.i_data;
                        acc_strb <= bus.i_ctrl;
                        state    <= S_ACCESS;
                        busy     <= 1'b1;
                        cnt      <= 32'd0;
                    end
`ifdef MEM_RESP_REFRESH_EN
                    else if (ref_due) begin
                        state <= S_REFRESH;
                        busy  <= 1'b1;
                        cnt   <= 32'd0;
                    end
`endif
                end
                S_ACCESS: begin
                    if (cnt == LAT_LAST) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        cnt   <= 32'd0;
                        if (!acc_wr) rdata <= mem[acc_addr];
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
`ifdef MEM_RESP_REFRESH_EN
                S_REFRESH: begin
                    // First request level seen is captured; busy never drops before its access.
                    if (!pend_vld && req) begin
                        pend_vld <= 1'b1;
                        acc_wr   <= bus.i_wr_en;
                        acc_addr <= bus.i_addr[ADDR_WIDTH-1:2];
                        acc_data <= bus.i_data;
                        acc_strb <= bus.i_ctrl;
                    end
                    if (cnt == RF_LAST) begin
                        cnt <= 32'd0;
                        if (pend_vld || req) begin
                            state    <= S_ACCESS;
                            pend_vld <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
`endif
                default: begin
                    state <= S_INIT;
                    busy  <= 1'b1;
                    cnt   <= 32'd0;
                end
            endcase
        end
    end

    assign bus.o_busy      = busy;
    assign bus.o_data      = rdata;
    assign bus.o_init_done = init_done;
endmodule

// File: tb/tb_mem_resp_bram.sv
// Directed plus randomized check of mem_resp_bram against a word-array reference model.
module tb_mem_resp_bram;
    localparam int AW   = 10;
    localparam int LAT  = 4;
    localparam int INIT = 16;
    localparam int RP   = 32;
    localparam int RC   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_resp_if bus();

    mem_resp_bram #(
        .ADDR_WIDTH(AW), .LATENCY(LAT), .INIT_CYCLES(INIT), .PRELOAD_FILE(""),
        .REFRESH_PERIOD(RP), .REFRESH_CYCLES(RC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] model [256];
    logic [31:0] exp_data;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.o_busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check(32'(bus.o_busy), 32'd0, {tag, "_idle_timeout"});
    endtask

    // Issue one request from an idle negedge; returns at the negedge where busy has fallen.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit hold, input string tag);
        int n;
        logic [7:0] w;
        wait_idle(tag);
        bus.i_rd_en = rd;
        bus.i_wr_en = wr;
        bus.i_addr  = a;
        bus.i_data  = d;
        bus.i_ctrl  = s;
        @(negedge clk);
        check(32'(bus.o_busy), 32'd1, {tag, "_busy_rise"});
        if (!hold) begin
            bus.i_rd_en = 1'b0;
            bus.i_wr_en = 1'b0;
        end
        n = 1;
        while (n < LAT + 20) begin
            @(negedge clk);
            if (bus.o_busy !== 1'b1) break;
            n++;
        end
        check(32'(n), 32'(LAT), {tag, "_busy_len"});
        w = a[AW-1:2];
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model[w][8*b +: 8] = d[8*b +: 8];
        end else if (rd) begin
            exp_data = model[w];
        end
        check(bus.o_data, exp_data, {tag, "_rdata"});
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int kind;
        int n;

        for (int i = 0; i < 256; i++) model[i] = 32'd0;
        exp_data    = 32'd0;
        bus.i_rd_en = 1'b0;
        bus.i_wr_en = 1'b0;
        bus.i_addr  = 32'd0;
        bus.i_data  = 32'd0;
        bus.i_ctrl  = 4'd0;

        repeat (3) @(negedge clk);
        check(32'(bus.o_busy), 32'd1, "rst_busy");
        check(32'(bus.o_init_done), 32'd0, "rst_init_done");
        check(bus.o_data, 32'd0, "rst_data");

        // Read held through INIT must be taken on the first IDLE cycle.
        bus.i_rd_en = 1'b1;
        bus.i_addr  = 32'h40;
        rst = 1'b0;
        for (int i = 0; i < INIT; i++) begin
            check(32'(bus.o_busy), 32'd1, "init_busy");
            check(32'(bus.o_init_done), 32'd0, "init_done_low");
            @(negedge clk);
        end
        check(32'(bus.o_busy), 32'd0, "init_end_busy");
        check(32'(bus.o_init_done), 32'd1, "init_end_done");
        access(1'b1, 1'b0, 32'h40, 32'd0, 4'h0, 1'b0, "init_read");

        access(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, "wr_full");
        access(1'b1, 1'b0, 32'h100, 32'd0, 4'h0, 1'b0, "rd_full");
        check(bus.o_data, 32'hDEADBEEF, "rd_full_const");

        access(1'b0, 1'b1, 32'h100, 32'h11223344, 4'b0101, 1'b0, "wr_strb5");
        access(1'b1, 1'b0, 32'h100, 32'd0, 4'h0, 1'b0, "rd_strb5");
        check(bus.o_data, 32'hDE22BE44, "rd_strb5_const");

        access(1'b0, 1'b1, 32'h100, 32'hCAFEF00D, 4'h0, 1'b0, "wr_strb0");
        access(1'b1, 1'b0, 32'h100, 32'd0, 4'h0, 1'b0, "rd_strb0");
        check(bus.o_data, 32'hDE22BE44, "rd_strb0_const");

        access(1'b1, 1'b1, 32'h200, 32'h5, 4'hF, 1'b0, "both");
        check(bus.o_data, 32'hDE22BE44, "both_data_kept");
        access(1'b1, 1'b0, 32'h200, 32'd0, 4'h0, 1'b0, "rd_after_both");
        check(bus.o_data, 32'h5, "rd_after_both_const");

        // Request still high when busy falls is accepted in that same cycle.
        access(1'b1, 1'b0, 32'h100, 32'd0, 4'h0, 1'b1, "hold_a");
        access(1'b1, 1'b0, 32'h100, 32'd0, 4'h0, 1'b0, "hold_b");

        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 3);
            a = $urandom;
            a[AW-1:2] = 8'($urandom_range(0, 15));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            access(kind == 0 || kind == 2, kind != 0, a, d, s, 1'b0, "rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset during the third busy cycle of a write drops that write.
        access(1'b0, 1'b1, 32'h300, 32'h0BADF00D, 4'hF, 1'b0, "pre_rst_wr");
        access(1'b1, 1'b0, 32'h300, 32'd0, 4'h0, 1'b0, "pre_rst_rd");
        wait_idle("rst_wr");
        bus.i_wr_en = 1'b1;
        bus.i_addr  = 32'h300;
        bus.i_data  = 32'h12345678;
        bus.i_ctrl  = 4'hF;
        @(negedge clk);
        check(32'(bus.o_busy), 32'd1, "rst_wr_busy1");
        bus.i_wr_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check(32'(bus.o_busy), 32'd1, "rst_wr_busy3");
        rst = 1'b1;
        #1;
        check(32'(bus.o_busy), 32'd1, "midrst_busy");
        check(32'(bus.o_init_done), 32'd0, "midrst_init_done");
        check(bus.o_data, 32'd0, "midrst_data");
        exp_data = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        wait_idle("post_rst");
        check(32'(bus.o_init_done), 32'd1, "post_rst_init_done");
        access(1'b1, 1'b0, 32'h300, 32'd0, 4'h0, 1'b0, "post_rst_rd");
        check(bus.o_data, 32'h0BADF00D, "post_rst_rd_const");

`ifdef MEM_RESP_REFRESH_EN
        // Wait idle for a refresh, then raise a read two cycles into it.
        n = 0;
        while (bus.o_busy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(32'(n < 200), 32'd1, "ref_start_seen");
        @(negedge clk);
        bus.i_rd_en = 1'b1;
        bus.i_addr  = 32'h100;
        n = 2;
        while (n < RC + LAT + 20) begin
            @(negedge clk);
            bus.i_rd_en = 1'b0;
            if (bus.o_busy !== 1'b1) break;
            n++;
        end
        check(32'(n), 32'(RC + LAT), "ref_busy_len");
        exp_data = model[8'h40];
        check(bus.o_data, exp_data, "ref_rdata");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
